// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART: frame constants and the TX/RX state encodings.
package uart_pkg;

  localparam int   DATA_BITS = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    TX_IDLE  = 3'd0,
    TX_START = 3'd1,
    TX_DATA  = 3'd2,
    TX_STOP  = 3'd3,
    TX_DONE  = 3'd4
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_8_if.sv
// Byte-side and serial-pin signals of the UART; slave is the UART itself, master its user.
interface uart_8_if;
  import uart_pkg::*;

  logic                 rxEn;
  logic                 rxIn;
  logic                 rxBusy;
  logic                 rxDone;
  logic                 rxErr;
  logic [DATA_BITS-1:0] rxOut;
  logic                 txEn;
  logic                 txStart;
  logic [DATA_BITS-1:0] txIn;
  logic                 txBusy;
  logic                 txDone;
  logic                 txOut;

  modport slave (
    input  rxEn, rxIn, txEn, txStart, txIn,
    output rxBusy, rxDone, rxErr, rxOut, txBusy, txDone, txOut
  );

  modport master (
    output rxEn, rxIn, txEn, txStart, txIn,
    input  rxBusy, rxDone, rxErr, rxOut, txBusy, txDone, txOut
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 receiver: oversampled by OVERSAMPLE ticks per bit, each bit sampled at its middle tick.
module uart_rx
  import uart_pkg::*;
#(
  parameter int RX_DIV     = 78,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 line,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [DATA_BITS-1:0] data
);

  localparam int CW = (RX_DIV > 1) ? $clog2(RX_DIV) : 1;
  localparam int TW = $clog2(OVERSAMPLE) + 1;

  rx_state_t            state_r;
  logic [1:0]           sync_r;
  logic [CW-1:0]        div_r;
  logic [TW-1:0]        tick_cnt_r;
  logic [2:0]           bit_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 rx_s;
  logic                 tick_s;

  assign rx_s   = sync_r[1];
  assign tick_s = (div_r == CW'(RX_DIV - 1));

  // Synchronizer, tick divider and frame sequencer; the sync chain idles high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= RX_IDLE;
      sync_r     <= 2'b11;
      div_r      <= '0;
      tick_cnt_r <= '0;
      bit_r      <= 3'd0;
      shift_r    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      data       <= '0;
    end else begin
      sync_r <= {sync_r[0], line};
      done   <= 1'b0;
      err    <= 1'b0;
      div_r  <= tick_s ? '0 : div_r + CW'(1);
      if (tick_s) begin
        tick_cnt_r <= tick_cnt_r + TW'(1);
      end
      if (!en) begin
        state_r <= RX_IDLE;
        busy    <= 1'b0;
      end else begin
        case (state_r)
          RX_IDLE: begin
            if (rx_s == START_BIT) begin
              div_r      <= '0;
              tick_cnt_r <= '0;
              busy       <= 1'b1;
              state_r    <= RX_START;
            end
          end
          RX_START: begin
            if (tick_s && tick_cnt_r == TW'(OVERSAMPLE / 2 - 1)) begin
              tick_cnt_r <= '0;
              bit_r      <= 3'd0;
              if (rx_s != START_BIT) begin
                busy    <= 1'b0;
                state_r <= RX_IDLE;
              end else begin
                state_r <= RX_DATA;
              end
            end
          end
          RX_DATA: begin
            if (tick_s && tick_cnt_r == TW'(OVERSAMPLE - 1)) begin
              tick_cnt_r <= '0;
              shift_r    <= {rx_s, shift_r[DATA_BITS-1:1]};
              bit_r      <= bit_r + 3'd1;
              if (bit_r == 3'(DATA_BITS - 1)) begin
                state_r <= RX_STOP;
              end
            end
          end
          RX_STOP: begin
            if (tick_s && tick_cnt_r == TW'(OVERSAMPLE - 1)) begin
              tick_cnt_r <= '0;
              busy       <= 1'b0;
              state_r    <= RX_IDLE;
              if (rx_s == STOP_BIT) begin
                data <= shift_r;
                done <= 1'b1;
              end else begin
                err <= 1'b1;
              end
            end
          end
          default: begin
            state_r <= RX_IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 transmitter: one frame per accepted request, each bit held for TX_DIV clocks.
module uart_tx
  import uart_pkg::*;
#(
  parameter int TX_DIV = 1250
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] data,
  output logic                 busy,
  output logic                 done,
  output logic                 line
);

  localparam int CW = (TX_DIV > 1) ? $clog2(TX_DIV) : 1;

  tx_state_t            state_r;
  logic [CW-1:0]        div_r;
  logic [2:0]           bit_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 bit_end_s;

  assign bit_end_s = (div_r == CW'(TX_DIV - 1));

  // Frame sequencer; dropping en in any line-driving state abandons the frame at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= TX_IDLE;
      div_r   <= '0;
      bit_r   <= 3'd0;
      shift_r <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      line    <= STOP_BIT;
    end else begin
      done  <= 1'b0;
      div_r <= bit_end_s ? '0 : div_r + CW'(1);
      if (!en && (state_r == TX_START || state_r == TX_DATA || state_r == TX_STOP)) begin
        state_r <= TX_IDLE;
        div_r   <= '0;
        busy    <= 1'b0;
        line    <= STOP_BIT;
      end else begin
        case (state_r)
          TX_IDLE: begin
            div_r <= '0;
            if (en && start) begin
              shift_r <= data;
              busy    <= 1'b1;
              line    <= START_BIT;
              state_r <= TX_START;
            end
          end
          TX_START: begin
            if (bit_end_s) begin
              line    <= shift_r[0];
              shift_r <= shift_r >> 1;
              bit_r   <= 3'd0;
              state_r <= TX_DATA;
            end
          end
          TX_DATA: begin
            if (bit_end_s) begin
              if (bit_r == 3'(DATA_BITS - 1)) begin
                line    <= STOP_BIT;
                state_r <= TX_STOP;
              end else begin
                line    <= shift_r[0];
                shift_r <= shift_r >> 1;
                bit_r   <= bit_r + 3'd1;
              end
            end
          end
          TX_STOP: begin
            if (bit_end_s) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              state_r <= TX_DONE;
            end
          end
          TX_DONE: begin
            state_r <= TX_IDLE;
          end
          default: begin
            state_r <= TX_IDLE;
            busy    <= 1'b0;
            line    <= STOP_BIT;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/uart_8.sv
// Full-duplex 8N1 UART: independent transmitter and receiver sharing only the clock and reset.
module uart_8
  import uart_pkg::*;
#(
  parameter int CLOCK_RATE    = 12000000,
  parameter int BAUD_RATE     = 9600,
  parameter int RX_OVERSAMPLE = 16
) (
  input logic     clk,
  input logic     reset,
  uart_8_if.slave bus
);

  localparam int TX_DIV = CLOCK_RATE / BAUD_RATE;
  localparam int RX_DIV = CLOCK_RATE / (BAUD_RATE * RX_OVERSAMPLE);

  uart_tx #(
    .TX_DIV (TX_DIV)
  ) u_tx (
    .clk   (clk),
    .reset (reset),
    .en    (bus.txEn),
    .start (bus.txStart),
    .data  (bus.txIn),
    .busy  (bus.txBusy),
    .done  (bus.txDone),
    .line  (bus.txOut)
  );

  uart_rx #(
    .RX_DIV     (RX_DIV),
    .OVERSAMPLE (RX_OVERSAMPLE)
  ) u_rx (
    .clk   (clk),
    .reset (reset),
    .en    (bus.rxEn),
    .line  (bus.rxIn),
    .busy  (bus.rxBusy),
    .done  (bus.rxDone),
    .err   (bus.rxErr),
    .data  (bus.rxOut)
  );

endmodule

// File: tb/tb_uart_8.sv
// Directed and randomized bench for uart_8: loopback frames, enable gating, TX abort, RX errors, glitches, reset.
module tb_uart_8;

  localparam int CLOCK_RATE = 1600000;
  localparam int BAUD_RATE  = 9600;
  localparam int OVS        = 16;
  localparam int D          = CLOCK_RATE / BAUD_RATE;
  localparam int RD         = CLOCK_RATE / (BAUD_RATE * OVS);

  logic clk = 1'b0;
  logic reset;
  logic loop;
  logic rx_drv;

  int pass_n = 0;
  int total_n = 0;
  int cyc = 0;
  int rx_done_n = 0;
  int rx_err_n = 0;
  int tx_done_n = 0;
  int rx_busy_rise_n = 0;
  int both_n = 0;
  int rx_done_cyc = 0;
  logic busy_q = 1'b0;
  logic [7:0] exp_rx;

  uart_8_if bus ();

  uart_8 #(
    .CLOCK_RATE    (CLOCK_RATE),
    .BAUD_RATE     (BAUD_RATE),
    .RX_OVERSAMPLE (OVS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.rxIn = loop ? bus.txOut : rx_drv;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (bus.rxDone === 1'b1) begin
      rx_done_n   <= rx_done_n + 1;
      rx_done_cyc <= cyc;
    end
    if (bus.rxErr === 1'b1) rx_err_n <= rx_err_n + 1;
    if (bus.txDone === 1'b1) tx_done_n <= tx_done_n + 1;
    if (bus.rxDone === 1'b1 && bus.rxErr === 1'b1) both_n <= both_n + 1;
    if (bus.rxBusy === 1'b1 && busy_q !== 1'b1) rx_busy_rise_n <= rx_busy_rise_n + 1;
    busy_q <= bus.rxBusy;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_n++;
    assert (obs === exp) pass_n++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_clks(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_txOut"}, 32'(bus.txOut), 32'd1);
    chk({tag, "_txBusy"}, 32'(bus.txBusy), 32'd0);
    chk({tag, "_txDone"}, 32'(bus.txDone), 32'd0);
    chk({tag, "_rxBusy"}, 32'(bus.rxBusy), 32'd0);
    chk({tag, "_rxDone"}, 32'(bus.rxDone), 32'd0);
    chk({tag, "_rxErr"}, 32'(bus.rxErr), 32'd0);
    chk({tag, "_rxOut"}, 32'(bus.rxOut), 32'd0);
  endtask

  // Sends one loopback frame and checks line waveform, txDone timing and the received byte.
  task automatic send_frame(input logic [7:0] data, input bit set_start);
    logic [9:0] frame;
    int base_rd, base_re, base_td, c0, off;
    frame   = {1'b1, data, 1'b0};
    base_rd = rx_done_n;
    base_re = rx_err_n;
    base_td = tx_done_n;
    bus.txIn = data;
    if (set_start) bus.txStart = 1'b1;
    step();
    c0 = cyc;
    bus.txIn = ~data;
    for (int i = 0; i < 10 * D; i++) begin
      chk("tx_line", 32'(bus.txOut), 32'(frame[i / D]));
      chk("tx_busy", 32'(bus.txBusy), 32'd1);
      if (i == 2 * D) bus.txStart = 1'b0;
      step();
    end
    chk("tx_done_pulse", 32'(bus.txDone), 32'd1);
    chk("tx_busy_at_done", 32'(bus.txBusy), 32'd0);
    chk("tx_idle_line", 32'(bus.txOut), 32'd1);
    step();
    chk("tx_done_one_clk", 32'(bus.txDone), 32'd0);
    chk("tx_done_count", 32'(tx_done_n - base_td), 32'd1);
    chk("rx_done_count", 32'(rx_done_n - base_rd), 32'd1);
    chk("rx_err_count", 32'(rx_err_n - base_re), 32'd0);
    off = rx_done_cyc - c0;
    chk("rx_done_in_stop", 32'(off >= 9 * D && off < 10 * D), 32'd1);
    exp_rx = data;
    chk("rx_out", 32'(bus.rxOut), 32'(exp_rx));
    chk("rx_busy_after", 32'(bus.rxBusy), 32'd0);
  endtask

  initial begin
    int b_rd, b_re, b_td, b_br;
    logic [9:0] eframe;
    logic [7:0] rnd;
    reset       = 1'b1;
    loop        = 1'b1;
    rx_drv      = 1'b1;
    bus.rxEn    = 1'b0;
    bus.txEn    = 1'b0;
    bus.txStart = 1'b0;
    bus.txIn    = 8'h00;
    exp_rx      = 8'h00;
    wait_clks(3);
    chk_reset_values("reset");
    reset = 1'b0;
    bus.rxEn = 1'b1;
    bus.txEn = 1'b1;
    step();

    // Loopback of 8'h8A
    send_frame(8'h8A, 1'b1);
    wait_clks(5);

    // txStart held with txEn low is ignored, then the frame begins on the enabling clock
    bus.txEn    = 1'b0;
    bus.txIn    = 8'h7A;
    bus.txStart = 1'b1;
    for (int i = 0; i < 40; i++) begin
      chk("gated_line", 32'(bus.txOut), 32'd1);
      chk("gated_busy", 32'(bus.txBusy), 32'd0);
      step();
    end
    bus.txEn = 1'b1;
    send_frame(8'h7A, 1'b0);
    wait_clks(5);

    // TX abort during data bit 7 with the receiver disabled
    bus.rxEn = 1'b0;
    b_rd = rx_done_n; b_re = rx_err_n; b_td = tx_done_n; b_br = rx_busy_rise_n;
    bus.txIn    = 8'h35;
    bus.txStart = 1'b1;
    step();
    for (int i = 0; i < 8 * D + D / 2; i++) begin
      if (i == 2 * D) bus.txStart = 1'b0;
      step();
    end
    chk("abort_pre_line", 32'(bus.txOut), 32'd0);
    chk("abort_pre_busy", 32'(bus.txBusy), 32'd1);
    bus.txEn = 1'b0;
    step();
    chk("abort_line", 32'(bus.txOut), 32'd1);
    chk("abort_busy", 32'(bus.txBusy), 32'd0);
    wait_clks(2 * D);
    chk("abort_no_txdone", 32'(tx_done_n - b_td), 32'd0);
    chk("abort_line_idle", 32'(bus.txOut), 32'd1);
    chk("rxoff_no_done", 32'(rx_done_n - b_rd), 32'd0);
    chk("rxoff_no_err", 32'(rx_err_n - b_re), 32'd0);
    chk("rxoff_no_busy", 32'(rx_busy_rise_n - b_br), 32'd0);
    chk("rxoff_rxout", 32'(bus.rxOut), 32'(exp_rx));
    bus.txEn = 1'b1;
    bus.rxEn = 1'b1;

    // Stop-bit framing error driven directly on rxIn
    loop   = 1'b0;
    rx_drv = 1'b1;
    wait_clks(20);
    b_rd = rx_done_n; b_re = rx_err_n;
    eframe = {1'b0, 8'h55, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rx_drv = eframe[k];
      wait_clks((k == 9) ? D / 2 : D);
    end
    rx_drv = 1'b1;
    wait_clks(2 * D);
    chk("stoperr_err", 32'(rx_err_n - b_re), 32'd1);
    chk("stoperr_no_done", 32'(rx_done_n - b_rd), 32'd0);
    chk("stoperr_rxout", 32'(bus.rxOut), 32'(exp_rx));
    chk("stoperr_busy", 32'(bus.rxBusy), 32'd0);

    // Short low glitch on rxIn
    b_rd = rx_done_n; b_re = rx_err_n;
    rx_drv = 1'b0;
    wait_clks(3 * RD);
    chk("glitch_busy_rise", 32'(bus.rxBusy), 32'd1);
    rx_drv = 1'b1;
    wait_clks(10 * RD);
    chk("glitch_busy_fall", 32'(bus.rxBusy), 32'd0);
    chk("glitch_no_done", 32'(rx_done_n - b_rd), 32'd0);
    chk("glitch_no_err", 32'(rx_err_n - b_re), 32'd0);
    loop = 1'b1;
    wait_clks(5);

    // Reset mid-frame on both directions, then a normal frame
    rnd = 8'($urandom);
    bus.txIn    = rnd;
    bus.txStart = 1'b1;
    step();
    wait_clks(5 * D);
    chk("pre_reset_txbusy", 32'(bus.txBusy), 32'd1);
    chk("pre_reset_rxbusy", 32'(bus.rxBusy), 32'd1);
    bus.txStart = 1'b0;
    reset = 1'b1;
    step();
    chk_reset_values("midreset");
    reset  = 1'b0;
    exp_rx = 8'h00;
    wait_clks(3);
    send_frame(8'($urandom), 1'b1);

    // Randomized loopback frames
    for (int n = 0; n < 5; n++) begin
      wait_clks(int'($urandom_range(1, 20)));
      send_frame(8'($urandom), 1'b1);
    end

    chk("done_err_exclusive", 32'(both_n), 32'd0);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
